// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Purpose:
//   This is the instruction queue between fetch and decode. Fetch pushes
//   {pc, inst} pairs into a small circular FIFO. Decode sees the head entry,
//   qualified by id_valid. When the queue is full, pc_stall holds fetch. A
//   taken branch (br_ctrl) empties the queue.
//
// Configuration:
//   IFQ_BYPASS_EN  When defined, a word from fetch that arrives while the
//                  queue is empty goes to decode combinationally in the same
//                  cycle. If decode takes it, the word is never stored.
//
// Parameters:
//   DEPTH     number of entries (power of two, >= 2)
//   NOP_INST  word presented on id_inst while the queue is empty
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   if_pc     pc of the word fetch is presenting
//   if_inst   instruction word fetch is presenting
//   if_valid  fetch word valid this cycle
//   br_ctrl   taken-branch redirect; flushes the queue
//   id_stall  decode cannot accept the head entry this cycle
//   pc_stall  queue full; fetch must hold its pc
//   id_pc     pc of the head entry
//   id_inst   instruction word of the head entry
//   id_valid  head entry is valid
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_valid,
    input  logic        br_ctrl,
    input  logic        id_stall,
    output logic        pc_stall,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    // Each entry is {pc, inst}.
    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    // full and empty come from the registered count, so they do not glitch.
    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
    // Gating with rst keeps id_* at their reset values while reset is
    // asserted, even if fetch presents a word.
    assign w_bypass = rst & w_empty & if_valid & ~br_ctrl;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that decode accepts in the same cycle is never stored.
    // The bypass only happens when the queue is empty, so pop is 0 then.
    assign w_push = if_valid & ~w_full & ~br_ctrl & ~(w_bypass & ~id_stall);
    assign w_pop  = ~w_empty & ~id_stall & ~br_ctrl;

    assign pc_stall = w_full;
    assign id_valid = ~w_empty | w_bypass;

    always_comb begin
        id_pc   = 32'h0;
        id_inst = NOP_INST;
        if (w_bypass) begin
            id_pc   = if_pc;
            id_inst = if_inst;
        end else if (!w_empty) begin
            id_pc   = r_mem[r_rd_ptr][63:32];
            id_inst = r_mem[r_rd_ptr][31:0];
        end
    end

    // The storage has no reset. Only the pointers and count mark an entry as live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {if_pc, if_inst};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (br_ctrl) begin
            // Flush has priority over push, pop and id_stall.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        br_ctrl;
    logic        id_stall;
    logic        pc_stall;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_valid (if_valid),
        .br_ctrl  (br_ctrl),
        .id_stall (id_stall),
        .pc_stall (pc_stall),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the inputs for one cycle and check the outputs against the
    // scoreboard before the edge. At the edge, apply the accepted push/pop/flush.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic br, input string tag);
        logic byp;
        logic full;
        logic push;
        logic pop;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_stall = st;
        br_ctrl  = br;
        #1;
`ifdef IFQ_BYPASS_EN
        byp = (sb.size() == 0) && v && !br;
`else
        byp = 1'b0;
`endif
        full = (sb.size() == DEPTH);
        if (byp) begin
            chk({tag, ".valid"}, 64'(id_valid), 64'd1);
            chk({tag, ".pc"},    64'(id_pc),    64'(pc));
            chk({tag, ".inst"},  64'(id_inst),  64'(inst));
        end else if (sb.size() != 0) begin
            chk({tag, ".valid"}, 64'(id_valid), 64'd1);
            chk({tag, ".pc"},    64'(id_pc),    64'(sb[0].pc));
            chk({tag, ".inst"},  64'(id_inst),  64'(sb[0].inst));
        end else begin
            chk({tag, ".valid"}, 64'(id_valid), 64'd0);
            chk({tag, ".pc"},    64'(id_pc),    64'd0);
            chk({tag, ".inst"},  64'(id_inst),  64'(NOP));
        end
        chk({tag, ".pc_stall"}, 64'(pc_stall), 64'(full));
        chk({tag, ".count"},    64'(dut.r_count), 64'(sb.size()));
        push = v && !full && !br && !(byp && !st);
        pop  = (sb.size() != 0) && !st && !br;
        @(posedge clk);
        if (br) begin
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back('{pc: pc, inst: inst});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        br_ctrl = 1'b0; id_stall = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst.valid", 64'(id_valid), 64'd0);
        chk("rst.pc", 64'(id_pc), 64'd0);
        chk("rst.inst", 64'(id_inst), 64'(NOP));
        chk("rst.pc_stall", 64'(pc_stall), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Stream three words with decode always ready.
        step(1'b1, 32'h0, 32'h0010_0093, 1'b0, 1'b0, "stream0");
        step(1'b1, 32'h4, 32'h0020_0113, 1'b0, 1'b0, "stream1");
        step(1'b1, 32'h8, 32'h0030_0193, 1'b0, 1'b0, "stream2");
        idle(2, "stream_drain");

        // Fill to full with decode stalled. The fifth word must be dropped.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, "fill");
        step(1'b1, 32'h10, 32'hA000_0004, 1'b0, 1'b0, "full_pop");
        idle(5, "full_drain");

        // Flush with a word presented in the flush cycle.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h80 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0, "fl_fill");
        step(1'b1, 32'h100, 32'hB000_0100, 1'b0, 1'b1, "flush");
        step(1'b1, 32'h104, 32'hB000_0104, 1'b1, 1'b1, "flush_hold");
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "post_flush");

        // Ten words through the queue at count 2, wrapping the pointers.
        step(1'b1, 32'h300, 32'hC000_0000, 1'b1, 1'b0, "wrap_pre0");
        step(1'b1, 32'h304, 32'hC000_0001, 1'b1, 1'b0, "wrap_pre1");
        for (int i = 2; i < 10; i++)
            step(1'b1, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, "wrap");
        idle(3, "wrap_drain");

        // Async reset between edges while three entries are queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h180 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b1, 1'b0, "ar_fill");
        if_valid = 1'b0; id_stall = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst.valid", 64'(id_valid), 64'd0);
        chk("arst.pc", 64'(id_pc), 64'd0);
        chk("arst.inst", 64'(id_inst), 64'(NOP));
        chk("arst.pc_stall", 64'(pc_stall), 64'd0);
        sb.delete();
        #1 rst = 1'b1;
        @(negedge clk);
        step(1'b1, 32'h200, 32'hE000_0000, 1'b1, 1'b0, "ar_push");
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "ar_head");
        idle(2, "ar_drain");

`ifdef IFQ_BYPASS_EN
        // Bypass on an empty queue: first consumed, then stalled and stored.
        step(1'b1, 32'h40, 32'hF000_0040, 1'b0, 1'b0, "byp_take");
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "byp_after");
        step(1'b1, 32'h40, 32'hF000_0040, 1'b1, 1'b0, "byp_stall");
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "byp_held");
        idle(2, "byp_drain");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
